// File: rtl/modbus_rx_frame_buf.sv
// Modbus RX frame buffer.
// Collects one frame from the UART deframer, checks it (CRC-16 in RTU mode,
// hex decode plus LRC in ASCII mode) and holds a verified frame for the
// controller behind a registered random-access read port.
module modbus_rx_frame_buf #(
    parameter int MAX_LEN = 256,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ascii_en,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          frame_start_i,
    input  logic          frame_end_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          frm_valid_o,
    output logic [AW:0]   frm_len_o,
    input  logic          frm_ack_i,
    output logic          crc_err_o,
    output logic          lrc_err_o,
    output logic          ovf_err_o,
    output logic          drop_o,
    output logic          busy_o
);

    localparam int          PW      = AW + 1;
    localparam logic [AW:0] MAX_PTR = PW'(MAX_LEN);
    localparam logic [AW:0] RTU_MIN = PW'(4);
    localparam logic [AW:0] ASC_MIN = PW'(3);
    localparam logic [AW:0] PTR_ONE = PW'(1);
    localparam logic [AW:0] PTR_TWO = PW'(2);

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Frame accumulators
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [15:0] crc_reg, crc_next;
    logic [7:0]  lrc_reg, lrc_next;
    logic        phase_reg, phase_next;
    logic [3:0]  hi_nib_reg, hi_nib_next;
    logic        ovf_reg, ovf_next;
    logic        fmt_reg, fmt_next;
    logic        mode_reg, mode_next;

    // Result registers
    logic        frm_valid_reg, frm_valid_next;
    logic [AW:0] frm_len_reg, frm_len_next;
    logic        crc_err_reg, crc_err_next;
    logic        lrc_err_reg, lrc_err_next;
    logic        ovf_err_reg, ovf_err_next;
    logic        drop_reg, drop_next;
    logic [7:0]  rd_data_reg;

    // Frame buffer
    logic [7:0]  mem [0:MAX_LEN-1];
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]  wr_data;

    // Starting point for this cycle's byte: fresh values on a (re)start
    logic        start_cap;
    logic        active;
    logic [AW:0] ptr_b;
    logic [15:0] crc_b;
    logic [7:0]  lrc_b;
    logic        phase_b;
    logic        ovf_b;
    logic        fmt_b;
    logic        mode_b;

    // Values after this cycle's byte
    logic [AW:0] ptr_w;
    logic [15:0] crc_w;
    logic [7:0]  lrc_w;
    logic        phase_w;
    logic [3:0]  hi_nib_w;
    logic        ovf_w;
    logic        fmt_w;
    logic        store_w;
    logic [7:0]  sbyte_w;
    logic [4:0]  hex_w;

    // One byte of the Modbus CRC-16 (reflected polynomial 0xA001)
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // ASCII hex character to {valid, nibble}; letters are accepted in either case
    function automatic logic [4:0] hex_decode(input logic [7:0] ch);
        logic [4:0] res;
        res = 5'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end
        return res;
    endfunction

    // Pick fresh or running accumulators depending on whether a frame starts now
    always_comb begin
        start_cap = frame_start_i && (state_reg != ST_HOLD);
        active    = start_cap || (state_reg == ST_COLLECT);
        if (start_cap) begin
            ptr_b   = '0;
            crc_b   = 16'hFFFF;
            lrc_b   = 8'h00;
            phase_b = 1'b0;
            ovf_b   = 1'b0;
            fmt_b   = 1'b0;
            mode_b  = ascii_en;
        end else begin
            ptr_b   = wr_ptr_reg;
            crc_b   = crc_reg;
            lrc_b   = lrc_reg;
            phase_b = phase_reg;
            ovf_b   = ovf_reg;
            fmt_b   = fmt_reg;
            mode_b  = mode_reg;
        end
    end

    // Apply the incoming byte to the accumulators and produce the buffer write
    always_comb begin
        ptr_w    = ptr_b;
        crc_w    = crc_b;
        lrc_w    = lrc_b;
        phase_w  = phase_b;
        hi_nib_w = hi_nib_reg;
        ovf_w    = ovf_b;
        fmt_w    = fmt_b;
        store_w  = 1'b0;
        sbyte_w  = rx_data_i;
        hex_w    = hex_decode(rx_data_i);
        wr_en    = 1'b0;
        wr_addr  = ptr_b[AW-1:0];
        wr_data  = rx_data_i;

        if (active && rx_valid_i) begin
            if (!mode_b) begin
                store_w = 1'b1;
                crc_w   = crc16_byte(crc_b, rx_data_i);
            end else if (hex_w[4]) begin
                if (!phase_b) begin
                    hi_nib_w = hex_w[3:0];
                    phase_w  = 1'b1;
                end else begin
                    sbyte_w = {hi_nib_reg, hex_w[3:0]};
                    store_w = 1'b1;
                    lrc_w   = lrc_b + sbyte_w;
                    phase_w = 1'b0;
                end
            end else if (rx_data_i == CH_COLON) begin
                fmt_w = fmt_b;
            end else if (rx_data_i == CH_CR || rx_data_i == CH_LF) begin
                // line terminators must fall on a byte boundary
                if (phase_b) begin
                    fmt_w = 1'b1;
                end
            end else begin
                fmt_w = 1'b1;
            end

            if (store_w) begin
                if (ptr_b == MAX_PTR) begin
                    ovf_w = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_b[AW-1:0];
                    wr_data = sbyte_w;
                    ptr_w   = ptr_b + PTR_ONE;
                end
            end
        end
    end

    // Next-state, frame verdict and result pulses
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        crc_next       = crc_reg;
        lrc_next       = lrc_reg;
        phase_next     = phase_reg;
        hi_nib_next    = hi_nib_reg;
        ovf_next       = ovf_reg;
        fmt_next       = fmt_reg;
        mode_next      = mode_reg;
        frm_valid_next = frm_valid_reg;
        frm_len_next   = frm_len_reg;
        crc_err_next   = 1'b0;
        lrc_err_next   = 1'b0;
        ovf_err_next   = 1'b0;
        drop_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (frame_start_i) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // a new start abandons the frame in progress
                if (frame_start_i) begin
                    drop_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (frm_ack_i) begin
                    frm_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
                // the buffer is busy, so any frame starting now is lost
                if (frame_start_i) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (active) begin
            state_next  = ST_COLLECT;
            wr_ptr_next = ptr_w;
            crc_next    = crc_w;
            lrc_next    = lrc_w;
            phase_next  = phase_w;
            hi_nib_next = hi_nib_w;
            ovf_next    = ovf_w;
            fmt_next    = fmt_w;
            mode_next   = mode_b;

            if (frame_end_i) begin
                state_next = ST_IDLE;
                if (ovf_w) begin
                    ovf_err_next = 1'b1;
                end else if (mode_b ? (ptr_w < ASC_MIN) : (ptr_w < RTU_MIN)) begin
                    ovf_err_next = 1'b1;
                end else if (!mode_b && (crc_w != 16'h0000)) begin
                    crc_err_next = 1'b1;
                end else if (mode_b && ((lrc_w != 8'h00) || fmt_w)) begin
                    lrc_err_next = 1'b1;
                end else begin
                    frm_valid_next = 1'b1;
                    frm_len_next   = mode_b ? (ptr_w - PTR_ONE) : (ptr_w - PTR_TWO);
                    state_next     = ST_HOLD;
                end
            end
        end
    end

    // State and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            crc_reg       <= 16'hFFFF;
            lrc_reg       <= 8'h00;
            phase_reg     <= 1'b0;
            hi_nib_reg    <= 4'h0;
            ovf_reg       <= 1'b0;
            fmt_reg       <= 1'b0;
            mode_reg      <= 1'b0;
            frm_valid_reg <= 1'b0;
            frm_len_reg   <= '0;
            crc_err_reg   <= 1'b0;
            lrc_err_reg   <= 1'b0;
            ovf_err_reg   <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            crc_reg       <= crc_next;
            lrc_reg       <= lrc_next;
            phase_reg     <= phase_next;
            hi_nib_reg    <= hi_nib_next;
            ovf_reg       <= ovf_next;
            fmt_reg       <= fmt_next;
            mode_reg      <= mode_next;
            frm_valid_reg <= frm_valid_next;
            frm_len_reg   <= frm_len_next;
            crc_err_reg   <= crc_err_next;
            lrc_err_reg   <= lrc_err_next;
            ovf_err_reg   <= ovf_err_next;
            drop_reg      <= drop_next;
        end
    end

    // Buffer write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= mem[rd_addr_i];
        end
    end

    assign rd_data_o   = rd_data_reg;
    assign frm_valid_o = frm_valid_reg;
    assign frm_len_o   = frm_len_reg;
    assign crc_err_o   = crc_err_reg;
    assign lrc_err_o   = lrc_err_reg;
    assign ovf_err_o   = ovf_err_reg;
    assign drop_o      = drop_reg;
    assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_modbus_rx_frame_buf.sv
// Testbench for modbus_rx_frame_buf: directed Modbus frames plus randomized
// RTU/ASCII frames, checked against a frame-level reference model.
module tb_modbus_rx_frame_buf;

    localparam int MAX_LEN = 256;
    localparam int AW      = 8;
    localparam int K_OK    = 0;
    localparam int K_CRC   = 1;
    localparam int K_LRC   = 2;
    localparam int K_OVF   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ascii_en;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          frame_start_i;
    logic          frame_end_i;
    logic [AW-1:0] rd_addr_i;
    logic [7:0]    rd_data_o;
    logic          frm_valid_o;
    logic [AW:0]   frm_len_o;
    logic          frm_ack_i;
    logic          crc_err_o;
    logic          lrc_err_o;
    logic          ovf_err_o;
    logic          drop_o;
    logic          busy_o;

    modbus_rx_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ascii_en(ascii_en),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .frm_valid_o(frm_valid_o), .frm_len_o(frm_len_o), .frm_ack_i(frm_ack_i),
        .crc_err_o(crc_err_o), .lrc_err_o(lrc_err_o), .ovf_err_o(ovf_err_o),
        .drop_o(drop_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int crc_cnt = 0, lrc_cnt = 0, ovf_cnt = 0, drop_cnt = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_buf[$];
    logic [7:0] held_buf[$];
    int         exp_kind;
    int         exp_len;

    // Pulse tallies, sampled away from the active edge
    always @(negedge clk) begin
        if (crc_err_o) crc_cnt++;
        if (lrc_err_o) lrc_cnt++;
        if (ovf_err_o) ovf_cnt++;
        if (drop_o)    drop_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid_i    = 1'b0;
        frame_start_i = 1'b0;
        frame_end_i   = 1'b0;
        frm_ack_i     = 1'b0;
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'd48 && c <= 8'd57)  return int'(c) - 48;
        if (c >= 8'd65 && c <= 8'd70)  return int'(c) - 55;
        if (c >= 8'd97 && c <= 8'd102) return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexch(input logic [3:0] v, input bit lower);
        if (v < 4'd10) return 8'd48 + {4'd0, v};
        return (lower ? 8'd87 : 8'd55) + {4'd0, v};
    endfunction

    // Reference model: decode the wire bytes and classify the whole frame
    task automatic compute_expect(input bit mode);
        logic [7:0] dec[$];
        bit         fmt, have_hi;
        int         hi, v, n;
        logic [7:0] sum;
        dec.delete();
        fmt = 0; have_hi = 0; hi = 0; sum = 8'h00;
        foreach (tx_q[i]) begin
            if (!mode) begin
                dec.push_back(tx_q[i]);
            end else begin
                v = hexval(tx_q[i]);
                if (tx_q[i] == 8'h3A) begin
                    v = -2;
                end else if (v >= 0) begin
                    if (!have_hi) begin
                        hi = v; have_hi = 1;
                    end else begin
                        dec.push_back(8'(hi * 16 + v)); have_hi = 0;
                    end
                end else if (tx_q[i] == 8'h0D || tx_q[i] == 8'h0A) begin
                    if (have_hi) fmt = 1;
                end else begin
                    fmt = 1;
                end
            end
        end
        n = dec.size();
        foreach (dec[i]) sum = sum + dec[i];
        exp_buf.delete();
        for (int i = 0; i < n && i < MAX_LEN; i++) exp_buf.push_back(dec[i]);
        exp_len = 0;
        if (n > MAX_LEN)                        exp_kind = K_OVF;
        else if (n < (mode ? 3 : 4))            exp_kind = K_OVF;
        else if (!mode && crc16(dec) != 16'h0)  exp_kind = K_CRC;
        else if (mode && (sum != 8'h00 || fmt)) exp_kind = K_LRC;
        else begin
            exp_kind = K_OK;
            exp_len  = mode ? n - 1 : n - 2;
        end
    endtask

    task automatic build_rtu(input int len, input bit corrupt);
        logic [15:0] c;
        int p;
        tx_q.delete();
        for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
        c = crc16(tx_q);
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        if (corrupt) begin
            p = $urandom_range(0, tx_q.size() - 1);
            tx_q[p] = tx_q[p] ^ (8'h01 << $urandom_range(0, 7));
        end
    endtask

    task automatic build_ascii(input int len, input int corrupt);
        logic [7:0] data[$];
        logic [7:0] sum, b;
        int p;
        sum = 8'h00;
        tx_q.delete();
        tx_q.push_back(8'h3A);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            data.push_back(b);
            sum = sum + b;
        end
        data.push_back(8'h00 - sum);
        foreach (data[i]) begin
            tx_q.push_back(hexch(data[i][7:4], 1'($urandom_range(0, 1))));
            tx_q.push_back(hexch(data[i][3:0], 1'($urandom_range(0, 1))));
        end
        p = $urandom_range(1, tx_q.size() - 1);
        if (corrupt == 1) tx_q[p] = hexch(4'(hexval(tx_q[p]) + 1), 1'b0);
        if (corrupt == 2) tx_q.insert(p, 8'h47);
        if (corrupt == 3) tx_q.delete(p);
        tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
    endtask

    task automatic load_str(input string s);
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s.getc(i));
        tx_q.push_back(8'h0D);
        tx_q.push_back(8'h0A);
    endtask

    // Send tx_q with frame_start on the first byte; ASCII ends on LF, RTU end_gap cycles later
    task automatic drive_frame(input bit mode, input int end_gap, input bit with_end);
        for (int i = 0; i < tx_q.size(); i++) begin
            ascii_en      = mode;
            frame_start_i = (i == 0);
            rx_valid_i    = 1'b1;
            rx_data_i     = tx_q[i];
            frame_end_i   = with_end && mode && (i == tx_q.size() - 1);
            step();
            idle_inputs();
            if (i != tx_q.size() - 1 && $urandom_range(0, 3) == 0) step();
        end
        if (with_end && !mode) begin
            repeat (end_gap) step();
            frame_end_i = 1'b1;
            step();
            frame_end_i = 1'b0;
        end
    endtask

    // Compare the verdict visible right after frame_end, read back, release
    task automatic check_result(input string tag);
        check({tag, " valid"}, frm_valid_o, exp_kind == K_OK);
        check({tag, " crc_err"}, crc_err_o, exp_kind == K_CRC);
        check({tag, " lrc_err"}, lrc_err_o, exp_kind == K_LRC);
        check({tag, " ovf_err"}, ovf_err_o, exp_kind == K_OVF);
        if (exp_kind == K_OK) begin
            check({tag, " len"}, frm_len_o, exp_len);
            for (int a = 0; a < exp_buf.size(); a++) begin
                rd_addr_i = a[AW-1:0];
                step();
                check($sformatf("%s rd[%0d]", tag, a), rd_data_o, exp_buf[a]);
            end
            frm_ack_i = 1'b1;
            step();
            frm_ack_i = 1'b0;
            check({tag, " valid after ack"}, frm_valid_o, 0);
        end else begin
            step();
        end
        check({tag, " busy"}, busy_o, 0);
        check({tag, " pulses cleared"}, {crc_err_o, lrc_err_o, ovf_err_o}, 0);
    endtask

    task automatic run_frame(input string tag, input bit mode, input int end_gap);
        int d0;
        d0 = drop_cnt;
        compute_expect(mode);
        drive_frame(mode, end_gap, 1'b1);
        check_result(tag);
        check({tag, " no drop"}, drop_cnt - d0, 0);
    endtask

    int d0, e0, held_len;

    initial begin
        rst = 1'b1; ascii_en = 1'b0; rx_data_i = 8'h00; rd_addr_i = '0;
        idle_inputs();

        // Reset state
        repeat (3) step();
        check("reset valid", frm_valid_o, 0);
        check("reset busy", busy_o, 0);
        check("reset len", frm_len_o, 0);
        check("reset rd_data", rd_data_o, 0);
        check("reset pulses", {crc_err_o, lrc_err_o, ovf_err_o, drop_o}, 0);
        rst = 1'b0;
        step();

        // RTU reference frame, end 4 cycles after the last byte
        tx_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        compute_expect(1'b0);
        drive_frame(1'b0, 0, 1'b0);
        repeat (3) step();
        frame_end_i = 1'b1;
        check("rtu busy while collecting", busy_o, 1);
        check("rtu valid before end", frm_valid_o, 0);
        step();
        frame_end_i = 1'b0;
        check("rtu len 6", frm_len_o, 6);
        rd_addr_i = 0; step();
        check("rtu rd0", rd_data_o, 8'h01);
        rd_addr_i = 5; step();
        check("rtu rd5", rd_data_o, 8'h0A);
        check_result("rtu ok");
        $display("txn rtu reference frame kind=%0d len=%0d", exp_kind, exp_len);

        // Bad CRC
        tx_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCE};
        e0 = crc_cnt;
        run_frame("rtu badcrc", 1'b0, 4);
        check("rtu badcrc single pulse", crc_cnt - e0, 1);
        $display("txn rtu bad crc kind=%0d", exp_kind);

        // ASCII frames
        load_str(":01030000000AF2");
        run_frame("ascii upper", 1'b1, 0);
        $display("txn ascii upper kind=%0d len=%0d", exp_kind, exp_len);
        load_str(":01030000000af2");
        run_frame("ascii lower", 1'b1, 0);
        $display("txn ascii lower kind=%0d len=%0d", exp_kind, exp_len);
        load_str(":01030000000AF3");
        run_frame("ascii badlrc", 1'b1, 0);
        $display("txn ascii bad lrc kind=%0d", exp_kind);
        load_str(":010300G00000AF2");
        run_frame("ascii badchar", 1'b1, 0);
        $display("txn ascii bad char kind=%0d", exp_kind);

        // Oversize and undersize RTU
        tx_q.delete();
        for (int i = 0; i < 300; i++) tx_q.push_back(8'($urandom));
        run_frame("rtu 300B", 1'b0, 2);
        $display("txn rtu 300 bytes kind=%0d", exp_kind);
        tx_q = '{8'h01, 8'h02, 8'h03};
        run_frame("rtu 3B", 1'b0, 2);
        $display("txn rtu 3 bytes kind=%0d", exp_kind);

        // Held buffer: a second frame is dropped and leaves the buffer intact
        build_rtu(5, 1'b0);
        compute_expect(1'b0);
        drive_frame(1'b0, 2, 1'b1);
        check("hold first valid", frm_valid_o, 1);
        held_buf = exp_buf;
        held_len = exp_len;
        d0 = drop_cnt;
        e0 = crc_cnt + lrc_cnt + ovf_cnt;
        build_rtu(7, 1'b0);
        drive_frame(1'b0, 2, 1'b1);
        step();
        check("hold drop pulse", drop_cnt - d0, 1);
        check("hold no error", crc_cnt + lrc_cnt + ovf_cnt - e0, 0);
        check("hold still valid", frm_valid_o, 1);
        check("hold len kept", frm_len_o, held_len);
        for (int a = 0; a < held_buf.size(); a++) begin
            rd_addr_i = a[AW-1:0];
            step();
            check($sformatf("hold rd[%0d]", a), rd_data_o, held_buf[a]);
        end
        frm_ack_i = 1'b1; step(); frm_ack_i = 1'b0;
        check("hold released", frm_valid_o, 0);
        $display("txn held buffer drop len=%0d", held_len);
        build_rtu(6, 1'b0);
        run_frame("after release", 1'b0, 1);
        $display("txn frame after release kind=%0d len=%0d", exp_kind, exp_len);

        // Restart while collecting
        build_rtu(4, 1'b0);
        void'(tx_q.pop_back());
        drive_frame(1'b0, 0, 1'b0);
        d0 = drop_cnt;
        build_rtu(5, 1'b0);
        compute_expect(1'b0);
        drive_frame(1'b0, 3, 1'b1);
        check_result("restart");
        check("restart drop pulse", drop_cnt - d0, 1);
        $display("txn restart mid-frame kind=%0d len=%0d", exp_kind, exp_len);

        // Reset mid-frame
        build_rtu(6, 1'b0);
        repeat (4) void'(tx_q.pop_back());
        drive_frame(1'b0, 0, 1'b0);
        e0 = crc_cnt + lrc_cnt + ovf_cnt + drop_cnt;
        rst = 1'b1; step(); rst = 1'b0;
        check("rst busy", busy_o, 0);
        frame_end_i = 1'b1; step(); frame_end_i = 1'b0;
        step();
        check("rst no pulses", crc_cnt + lrc_cnt + ovf_cnt + drop_cnt - e0, 0);
        check("rst no valid", frm_valid_o, 0);
        $display("txn reset mid-frame");

        // Randomized frames
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                build_rtu($urandom_range(0, 16), ($urandom_range(0, 3) == 0));
                run_frame($sformatf("rand%0d rtu", t), 1'b0, $urandom_range(0, 4));
            end else begin
                build_ascii($urandom_range(0, 12),
                            ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
                run_frame($sformatf("rand%0d ascii", t), 1'b1, 0);
            end
            $display("txn random %0d kind=%0d len=%0d", t, exp_kind, exp_len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
